// File: rtl/antialias_dispatch.sv
// rtl/antialias_dispatch.sv - granule buffer and antialias pair dispatcher
module antialias_dispatch #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         new_frame_start,
  input  logic                         short_block,
  input  logic signed [DATA_WIDTH-1:0] ch1_in,
  input  logic signed [DATA_WIDTH-1:0] ch2_in,
  input  logic                         valid_in,
  output logic [9:0]                   x_pos_out,
  output logic [9:0]                   y_pos_out,
  output logic signed [DATA_WIDTH-1:0] ch1_x_out,
  output logic signed [DATA_WIDTH-1:0] ch1_y_out,
  output logic signed [DATA_WIDTH-1:0] ch2_x_out,
  output logic signed [DATA_WIDTH-1:0] ch2_y_out,
  output logic                         butterfly_out,
  output logic                         valid_out,
  output logic                         done_out
);

  localparam int LINES = 576;

  typedef enum logic [1:0] {
    S_LOAD = 2'b00,
    S_EMIT = 2'b01,
    S_DONE = 2'b10
  } state_t;

  // Emission walks three index regions: subband-boundary butterflies,
  // the leftover 8/9 pairs of each subband, then the granule edges.
  typedef enum logic [1:0] {
    PH_BF   = 2'b00,
    PH_MID  = 2'b01,
    PH_EDGE = 2'b10
  } phase_t;

  state_t      state_q, state_d;
  phase_t      phase_q, phase_d;
  logic [9:0]  load_cnt_q, load_cnt_d;
  logic [9:0]  base_q, base_d;
  logic [2:0]  bi_q, bi_d;
  logic [8:0]  pair_q, pair_d;
  logic        sb_lat_q, sb_lat_d;

  logic        wr_en;
  logic        issue;
  logic        mem_we;
  logic [9:0]  rd_x;
  logic [9:0]  rd_y;
  logic [9:0]  addr_a;
  logic        issue_bf;
  logic        issue_last;

  logic        v1_q, v2_q, bf1_q, bf2_q, last1_q, last2_q, done_q;
  logic [9:0]  x1_q, y1_q, x2_q, y2_q;

  logic signed [DATA_WIDTH-1:0] ch1_mem [0:LINES-1];
  logic signed [DATA_WIDTH-1:0] ch2_mem [0:LINES-1];
  logic signed [DATA_WIDTH-1:0] ch1_a_q, ch1_b_q, ch2_a_q, ch2_b_q;
  logic signed [DATA_WIDTH-1:0] ch1_x_q, ch1_y_q, ch2_x_q, ch2_y_q;

  // Next-state, load counter and pair-index generation (adders only).
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    load_cnt_d = load_cnt_q;
    base_d     = base_q;
    bi_d       = bi_q;
    pair_d     = pair_q;
    sb_lat_d   = sb_lat_q;
    wr_en      = 1'b0;
    issue      = 1'b0;

    if (phase_q == PH_BF) begin
      rd_x = base_q - 10'd1 - {7'd0, bi_q};
      rd_y = base_q + {7'd0, bi_q};
    end else begin
      rd_x = base_q;
      rd_y = base_q + 10'd1;
    end

    case (state_q)
      S_LOAD: begin
        if (valid_in) begin
          wr_en = 1'b1;
          if (load_cnt_q == 10'd0) sb_lat_d = short_block;
          if (load_cnt_q == 10'(LINES - 1)) begin
            load_cnt_d = 10'd0;
            state_d    = S_EMIT;
            phase_d    = PH_BF;
            base_d     = 10'd18;
            bi_d       = 3'd0;
            pair_d     = 9'd0;
          end else begin
            load_cnt_d = load_cnt_q + 10'd1;
          end
        end
      end
      S_EMIT: begin
        issue  = 1'b1;
        pair_d = pair_q + 9'd1;
        case (phase_q)
          PH_BF: begin
            if (bi_q == 3'd7) begin
              bi_d = 3'd0;
              if (base_q == 10'd558) begin
                phase_d = PH_MID;
                base_d  = 10'd8;
              end else begin
                base_d = base_q + 10'd18;
              end
            end else begin
              bi_d = bi_q + 3'd1;
            end
          end
          PH_MID: begin
            if (base_q == 10'd566) begin
              phase_d = PH_EDGE;
              base_d  = 10'd0;
            end else begin
              base_d = base_q + 10'd18;
            end
          end
          default: begin
            base_d = (base_q == 10'd6) ? 10'd568 : base_q + 10'd2;
          end
        endcase
        if (pair_q == 9'd287) begin
          state_d = S_DONE;
          pair_d  = 9'd0;
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_LOAD;
      end
    endcase

    // A new frame overrides everything, including a same-cycle sample.
    if (new_frame_start) begin
      state_d    = S_LOAD;
      load_cnt_d = 10'd0;
      pair_d     = 9'd0;
      phase_d    = PH_BF;
      base_d     = 10'd18;
      bi_d       = 3'd0;
      wr_en      = 1'b0;
      issue      = 1'b0;
    end
  end

  assign mem_we     = wr_en & ~rst;
  assign addr_a     = wr_en ? load_cnt_q : rd_x;
  assign issue_bf   = issue & (phase_q == PH_BF) & ~sb_lat_q;
  assign issue_last = issue & (pair_q == 9'd287);

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_LOAD;
      phase_q    <= PH_BF;
      load_cnt_q <= 10'd0;
      base_q     <= 10'd18;
      bi_q       <= 3'd0;
      pair_q     <= 9'd0;
      sb_lat_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      load_cnt_q <= load_cnt_d;
      base_q     <= base_d;
      bi_q       <= bi_d;
      pair_q     <= pair_d;
      sb_lat_q   <= sb_lat_d;
    end
  end

  // Dual-port line RAMs: port A writes or reads x, port B reads y; first read register.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      ch1_mem[addr_a] <= ch1_in;
      ch2_mem[addr_a] <= ch2_in;
    end
    ch1_a_q <= ch1_mem[addr_a];
    ch2_a_q <= ch2_mem[addr_a];
    ch1_b_q <= ch1_mem[rd_y];
    ch2_b_q <= ch2_mem[rd_y];
  end

  // Second RAM read register; held at zero whenever the pair is not valid.
  always_ff @(posedge clk) begin
    if (rst || !v1_q) begin
      ch1_x_q <= '0;
      ch1_y_q <= '0;
      ch2_x_q <= '0;
      ch2_y_q <= '0;
    end else begin
      ch1_x_q <= ch1_a_q;
      ch1_y_q <= ch1_b_q;
      ch2_x_q <= ch2_a_q;
      ch2_y_q <= ch2_b_q;
    end
  end

  // Two-stage sideband pipeline aligned with the RAM read latency.
  always_ff @(posedge clk) begin
    if (rst || new_frame_start) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      bf1_q   <= 1'b0;
      bf2_q   <= 1'b0;
      last1_q <= 1'b0;
      last2_q <= 1'b0;
      done_q  <= 1'b0;
      x1_q    <= 10'd0;
      y1_q    <= 10'd0;
      x2_q    <= 10'd0;
      y2_q    <= 10'd0;
    end else begin
      v1_q    <= issue;
      v2_q    <= v1_q;
      bf1_q   <= issue_bf;
      bf2_q   <= bf1_q;
      last1_q <= issue_last;
      last2_q <= last1_q;
      done_q  <= v2_q & last2_q;
      x1_q    <= issue ? rd_x : 10'd0;
      y1_q    <= issue ? rd_y : 10'd0;
      x2_q    <= x1_q;
      y2_q    <= y1_q;
    end
  end

  assign x_pos_out     = x2_q;
  assign y_pos_out     = y2_q;
  assign ch1_x_out     = ch1_x_q;
  assign ch1_y_out     = ch1_y_q;
  assign ch2_x_out     = ch2_x_q;
  assign ch2_y_out     = ch2_y_q;
  assign butterfly_out = bf2_q;
  assign valid_out     = v2_q;
  assign done_out      = done_q;

endmodule

// File: tb/tb_antialias_dispatch.sv
// tb/tb_antialias_dispatch.sv - scoreboard bench for antialias_dispatch
module tb_antialias_dispatch;

  logic               clk;
  logic               rst;
  logic               new_frame_start;
  logic               short_block;
  logic signed [31:0] ch1_in, ch2_in;
  logic               valid_in;
  logic [9:0]         x_pos_out, y_pos_out;
  logic signed [31:0] ch1_x_out, ch1_y_out, ch2_x_out, ch2_y_out;
  logic               butterfly_out, valid_out, done_out;

  antialias_dispatch #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .new_frame_start(new_frame_start),
    .short_block(short_block), .ch1_in(ch1_in), .ch2_in(ch2_in),
    .valid_in(valid_in), .x_pos_out(x_pos_out), .y_pos_out(y_pos_out),
    .ch1_x_out(ch1_x_out), .ch1_y_out(ch1_y_out),
    .ch2_x_out(ch2_x_out), .ch2_y_out(ch2_y_out),
    .butterfly_out(butterfly_out), .valid_out(valid_out), .done_out(done_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int     x;
    int     y;
    longint c1x;
    longint c1y;
    longint c2x;
    longint c2y;
    int     bf;
  } exp_t;

  exp_t   exp_q[$];
  exp_t   mon_e;
  int     errors = 0;
  int     checks = 0;
  int     px[288];
  int     py[288];
  int     seen_cnt[576];
  int     oob_cnt = 0;
  int     pairs_seen = 0;
  int     done_count = 0;
  bit     prev_valid = 1'b0;
  int     act_x[288], act_y[288], act_bf[288];
  longint act_c1x[288], act_c2y[288];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic logic signed [31:0] dval(input int pat, input int ch, input int idx);
    case (pat)
      0:       return (ch == 1) ? idx : -idx;
      1:       return (ch == 1) ? 1000 + 3 * idx : 7 * idx - 5000;
      2:       return (ch == 1) ? -11 * idx - 1 : idx * idx;
      default: return (ch == 1) ? 32'sh5a5a0000 + idx : -(13 * idx + 2);
    endcase
  endfunction

  task automatic build_order();
    int p;
    p = 0;
    for (int sb = 1; sb <= 31; sb++)
      for (int i = 0; i < 8; i++) begin
        px[p] = 18 * sb - 1 - i;
        py[p] = 18 * sb + i;
        p++;
      end
    for (int k = 0; k < 32; k++) begin
      px[p] = 18 * k + 8;
      py[p] = 18 * k + 9;
      p++;
    end
    for (int x = 0; x <= 6; x += 2) begin
      px[p] = x; py[p] = x + 1; p++;
    end
    for (int x = 568; x <= 574; x += 2) begin
      px[p] = x; py[p] = x + 1; p++;
    end
  endtask

  task automatic push_expected(input int pat, input bit sb);
    exp_t e;
    for (int p = 0; p < 288; p++) begin
      e.x   = px[p];
      e.y   = py[p];
      e.c1x = dval(pat, 1, px[p]);
      e.c1y = dval(pat, 1, py[p]);
      e.c2x = dval(pat, 2, px[p]);
      e.c2y = dval(pat, 2, py[p]);
      e.bf  = (p < 248 && !sb) ? 1 : 0;
      exp_q.push_back(e);
    end
  endtask

  task automatic clear_granule();
    pairs_seen = 0;
    oob_cnt    = 0;
    for (int i = 0; i < 576; i++) seen_cnt[i] = 0;
  endtask

  task automatic load_granule(input int pat, input bit sb, input bit rnd);
    int i;
    bit v;
    i = 0;
    while (i < 576) begin
      v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      valid_in    = v;
      short_block = sb;
      ch1_in      = v ? dval(pat, 1, i) : 32'sh0bad0bad;
      ch2_in      = v ? dval(pat, 2, i) : 32'sh0bad0bad;
      @(posedge clk); #1;
      if (v) i++;
    end
    valid_in    = 1'b0;
    short_block = 1'b0;
    push_expected(pat, sb);
  endtask

  task automatic pulse_new_frame();
    new_frame_start = 1'b1;
    @(posedge clk); #1;
    new_frame_start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int start;
    int t;
    start = done_count;
    t = 0;
    while (done_count == start && t < 3000) begin
      @(posedge clk); #1;
      t++;
    end
    chk({name, "_done_seen"}, done_count - start, 1);
  endtask

  task automatic check_idle(input string name);
    chk({name, "_valid"}, valid_out, 0);
    chk({name, "_done"}, done_out, 0);
    chk({name, "_bf"}, butterfly_out, 0);
    chk({name, "_x"}, x_pos_out, 0);
    chk({name, "_y"}, y_pos_out, 0);
    chk({name, "_ch1x"}, ch1_x_out, 0);
    chk({name, "_ch1y"}, ch1_y_out, 0);
    chk({name, "_ch2x"}, ch2_x_out, 0);
    chk({name, "_ch2y"}, ch2_y_out, 0);
  endtask

  // Monitor: pops the scoreboard on every valid pair and audits each granule at done.
  always @(negedge clk) begin
    if (valid_out) begin
      if (pairs_seen > 0) chk("valid_consecutive", prev_valid, 1);
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("pair_x", x_pos_out, mon_e.x);
        chk("pair_y", y_pos_out, mon_e.y);
        chk("pair_bf", butterfly_out, mon_e.bf);
        chk("pair_ch1x", ch1_x_out, mon_e.c1x);
        chk("pair_ch1y", ch1_y_out, mon_e.c1y);
        chk("pair_ch2x", ch2_x_out, mon_e.c2x);
        chk("pair_ch2y", ch2_y_out, mon_e.c2y);
      end
      if (pairs_seen < 288) begin
        act_x[pairs_seen]   = int'(x_pos_out);
        act_y[pairs_seen]   = int'(y_pos_out);
        act_bf[pairs_seen]  = int'(butterfly_out);
        act_c1x[pairs_seen] = ch1_x_out;
        act_c2y[pairs_seen] = ch2_y_out;
      end
      if (x_pos_out < 10'd576) seen_cnt[x_pos_out]++; else oob_cnt++;
      if (y_pos_out < 10'd576) seen_cnt[y_pos_out]++; else oob_cnt++;
      pairs_seen++;
    end
    if (done_out) begin
      int bad;
      bad = oob_cnt;
      for (int i = 0; i < 576; i++) if (seen_cnt[i] != 1) bad++;
      chk("done_prev_valid", prev_valid, 1);
      chk("done_valid_low", valid_out, 0);
      chk("done_pair_count", pairs_seen, 288);
      chk("done_queue_empty", exp_q.size(), 0);
      chk("index_coverage_bad", bad, 0);
      clear_granule();
      done_count++;
    end
    prev_valid = valid_out;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    build_order();
    clear_granule();
    rst             = 1'b1;
    new_frame_start = 1'b0;
    short_block     = 1'b0;
    valid_in        = 1'b1;
    ch1_in          = 32'sh12345678;
    ch2_in          = 32'sh12345678;

    // Reset with valid_in active must neither write nor emit.
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check_idle("reset");
    @(posedge clk); #1;
    rst      = 1'b0;
    valid_in = 1'b0;
    @(negedge clk);
    check_idle("post_reset");
    @(posedge clk); #1;

    // Granule A: ramp data, long blocks, continuous valid.
    load_granule(0, 1'b0, 1'b0);
    wait_done("granA");
    chk("A_first_x", act_x[0], 17);
    chk("A_first_y", act_y[0], 18);
    chk("A_first_ch1x", act_c1x[0], 17);
    chk("A_first_ch2y", act_c2y[0], -18);
    chk("A_first_bf", act_bf[0], 1);
    chk("A_p247_x", act_x[247], 550);
    chk("A_p247_y", act_y[247], 565);
    chk("A_p248_x", act_x[248], 8);
    chk("A_p248_y", act_y[248], 9);
    chk("A_p248_bf", act_bf[248], 0);
    chk("A_last_x", act_x[287], 574);
    chk("A_last_y", act_y[287], 575);

    // Granule B: same data with gapped valid_in.
    pulse_new_frame();
    load_granule(0, 1'b0, 1'b1);
    wait_done("granB");

    // Granule C: short blocks, no butterflies.
    pulse_new_frame();
    load_granule(1, 1'b1, 1'b0);
    wait_done("granC");
    chk("C_first_bf", act_bf[0], 0);
    chk("C_first_x", act_x[0], 17);

    // Granule D: abort at pair 100, with a same-cycle sample that must be dropped.
    pulse_new_frame();
    load_granule(2, 1'b0, 1'b0);
    begin
      int t;
      t = 0;
      while (pairs_seen < 100 && t < 1000) begin
        @(posedge clk); #1;
        t++;
      end
      chk("D_reached_pair100", (pairs_seen >= 100) ? 1 : 0, 1);
    end
    valid_in        = 1'b1;
    ch1_in          = 32'sh7eadbeef;
    ch2_in          = 32'sh7eadbeef;
    new_frame_start = 1'b1;
    @(posedge clk); #1;
    new_frame_start = 1'b0;
    valid_in        = 1'b0;
    exp_q.delete();
    clear_granule();
    @(negedge clk);
    chk("D_abort_valid_low", valid_out, 0);
    chk("D_abort_bf_low", butterfly_out, 0);
    @(posedge clk); #1;
    load_granule(3, 1'b0, 1'b0);
    wait_done("granD");
    chk("D_restart_x", act_x[0], 17);
    chk("D_restart_y", act_y[0], 18);

    // valid_in while in DONE and during reset: ignored.
    valid_in = 1'b1;
    ch1_in   = 32'sh55aa55aa;
    ch2_in   = 32'sh55aa55aa;
    repeat (20) begin
      @(posedge clk); #1;
    end
    chk("E_done_no_valid", valid_out, 0);
    rst = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst      = 1'b0;
    valid_in = 1'b0;
    @(posedge clk); #1;
    load_granule(1, 1'b0, 1'b1);
    wait_done("granE");
    chk("E_first_ch1x", act_c1x[0], 1051);

    repeat (5) begin
      @(posedge clk); #1;
    end
    chk("final_queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
